// File: rtl/fetch_decode_register.sv
// fetch_decode_register: IF/ID pipeline stage.
// Captures PC and instruction from fetch and presents them to decode through a ready/valid
// handshake on both sides. A 2-entry store (MAIN drives the outputs, SKID catches the word that
// is already in flight when decode stalls) keeps if_ready_o a function of state only, so there
// is no combinational path from id_ready_i to if_ready_o. flush_i turns every held and incoming
// entry into a bubble.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   flush_i                          branch/jump taken: discard held and incoming entries
//   if_valid_i/if_ready_o            fetch-side handshake
//   if_pc_i, if_instr_i              fetched PC and instruction word
//   id_ready_i                       decode accepts the current entry (0 = stall)
//   fd_valid_o                       fd_* outputs hold a valid instruction
//   fd_pc_o, fd_pc_plus4_o           held PC and PC+4 (registered at capture)
//   fd_instr_o                       held instruction, NOP_INSTR when not valid
//   fd_opcode_o .. fd_rs2_o          instruction fields decoded from fd_instr_o
//   stall_cnt_o, flush_cnt_o         saturating perf counters (only with FD_PERF_CNT_EN)
//
// Configuration macro: FD_PERF_CNT_EN adds the two perf-counter output ports.

module fetch_decode_register #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
  parameter logic [XLEN-1:0]  RESET_PC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [XLEN-1:0] if_pc_i,
  input  logic [31:0]     if_instr_i,
  input  logic            id_ready_i,
  output logic            fd_valid_o,
  output logic [XLEN-1:0] fd_pc_o,
  output logic [XLEN-1:0] fd_pc_plus4_o,
  output logic [31:0]     fd_instr_o,
  output logic [6:0]      fd_opcode_o,
  output logic [4:0]      fd_rd_o,
  output logic [2:0]      fd_funct3_o,
  output logic [4:0]      fd_rs1_o,
  output logic [4:0]      fd_rs2_o
`ifdef FD_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt_o,
  output logic [31:0]     flush_cnt_o
`endif
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_main_in;
  logic            w_load_main_skid;
  logic            w_load_skid;

  logic [XLEN-1:0] r_main_pc;
  logic [XLEN-1:0] r_main_pc4;
  logic [31:0]     r_main_instr;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_pc4;
  logic [31:0]     r_skid_instr;

  assign if_ready_o = (r_state != StFull);
  assign fd_valid_o = (r_state != StEmpty);
  assign w_in_fire  = if_valid_i & if_ready_o;
  assign w_out_fire = fd_valid_o & id_ready_i;

  always_comb begin
    w_state_d        = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      StEmpty: begin
        if (w_in_fire) begin
          w_state_d      = StOne;
          w_load_main_in = 1'b1;
        end
      end
      StOne: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_d   = StFull;
          w_load_skid = 1'b1;
        end else if (w_out_fire) begin
          w_state_d = StEmpty;
        end
      end
      StFull: begin
        if (w_out_fire) begin
          w_state_d        = StOne;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_d = StEmpty;
    endcase
    // Flush wins over any transfer; an out_fire this cycle is still consumed by decode.
    if (flush_i) begin
      w_state_d        = StEmpty;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StEmpty;
      r_main_pc    <= RESET_PC;
      r_main_pc4   <= '0;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= '0;
      r_skid_pc4   <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_main_in) begin
        r_main_pc    <= if_pc_i;
        r_main_pc4   <= if_pc_i + PC_STEP;
        r_main_instr <= if_instr_i;
      end else if (w_load_main_skid) begin
        r_main_pc    <= r_skid_pc;
        r_main_pc4   <= r_skid_pc4;
        r_main_instr <= r_skid_instr;
      end
      if (w_load_skid) begin
        r_skid_pc    <= if_pc_i;
        r_skid_pc4   <= if_pc_i + PC_STEP;
        r_skid_instr <= if_instr_i;
      end
    end
  end

  assign fd_pc_o       = r_main_pc;
  assign fd_pc_plus4_o = r_main_pc4;
  // Bubbles present as NOP so decode sees harmless fields.
  assign fd_instr_o    = fd_valid_o ? r_main_instr : NOP_INSTR;
  assign fd_opcode_o   = fd_instr_o[6:0];
  assign fd_rd_o       = fd_instr_o[11:7];
  assign fd_funct3_o   = fd_instr_o[14:12];
  assign fd_rs1_o      = fd_instr_o[19:15];
  assign fd_rs2_o      = fd_instr_o[24:20];

`ifdef FD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (fd_valid_o && !id_ready_i && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (flush_i && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  // Perf counters not built.
`endif

endmodule
